// File: rtl/n_dff_pipe.sv
// n_dff_pipe: DEPTH-stage elastic register pipeline, valid/ready at both ends,
// with bubble collapsing, synchronous flush and a registered-state occupancy count.
module n_dff_pipe #(
    parameter int unsigned       N_BITS    = 8,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [N_BITS-1:0] RESET_VAL = '0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [N_BITS-1:0]          d_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [N_BITS-1:0]          q_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  en;
    logic [DEPTH-1:0]  up_v;
    logic [N_BITS-1:0] data [DEPTH];
    logic [N_BITS-1:0] up_d [DEPTH];
    logic [CW-1:0]     count;

    // A stage may load when any stage at or downstream of it is empty, or the
    // consumer takes the head; accumulated from the output end backwards.
    always_comb begin
        logic pass;
        pass = ready_i;
        en   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pass              = pass | ~v[DEPTH-1-i];
            en[DEPTH-1-i]     = pass;
        end
    end

    always_comb begin
        up_v    = '0;
        up_d    = '{default: '0};
        up_v[0] = valid_i;
        up_d[0] = d_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = data[i-1];
        end
    end

    // Flush overrides every load; data only captures words that stay valid.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data[i] <= RESET_VAL;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (flush_i) begin
                    v[i] <= 1'b0;
                end else if (en[i]) begin
                    v[i] <= up_v[i];
                    if (up_v[i]) begin
                        data[i] <= up_d[i];
                    end
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count = count + CW'(v[i]);
        end
    end

    assign ready_o = en[0];
    assign valid_o = v[DEPTH-1];
    assign q_o     = data[DEPTH-1];
    assign count_o = count;

endmodule

// File: tb/tb_n_dff_pipe.sv
// Bench for n_dff_pipe (N_BITS=8, DEPTH=3): a word-position model of the pipeline
// plus accepted/delivered logs, checked by directed and random scenarios.
module tb_n_dff_pipe;

    localparam int unsigned NB = 8;
    localparam int unsigned D  = 3;
    localparam int unsigned CW = $clog2(D + 1);

    logic          clk;
    logic          reset_i;
    logic          flush_i;
    logic          valid_i;
    logic          ready_o;
    logic [NB-1:0] d_i;
    logic          valid_o;
    logic          ready_i;
    logic [NB-1:0] q_o;
    logic [CW-1:0] count_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NB-1:0] d;
        int            st;
    } item_t;

    item_t         mq[$];
    logic [NB-1:0] sent[$];
    logic [NB-1:0] got[$];

    n_dff_pipe #(
        .N_BITS   (NB),
        .DEPTH    (D),
        .RESET_VAL(8'h00)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .flush_i(flush_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .d_i    (d_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .q_o    (q_o),
        .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: words oldest-first, each with the stage it sits in.
    function automatic bit m_valid();
        return (mq.size() > 0) && (mq[0].st == int'(D) - 1);
    endfunction

    function automatic bit m_ready(input bit ri);
        return ri || (mq.size() < int'(D));
    endfunction

    function automatic int m_count();
        return mq.size();
    endfunction

    function automatic logic [NB-1:0] m_q();
        return mq[0].d;
    endfunction

    // Advances one clock edge; each word moves forward one stage unless blocked
    // by the word ahead of it (after that word's own move).
    task automatic tick();
        bit            out, inp, fl;
        logic [NB-1:0] qd, dd;
        int            limit, nst;
        out = m_valid() && ready_i;
        inp = valid_i && m_ready(ready_i) && !flush_i;
        fl  = flush_i;
        qd  = q_o;
        dd  = d_i;
        @(posedge clk);
        if (out) begin
            got.push_back(qd);
            void'(mq.pop_front());
        end
        if (fl) begin
            mq.delete();
        end else begin
            limit = int'(D);
            foreach (mq[j]) begin
                nst = (mq[j].st + 1 < limit - 1) ? mq[j].st + 1 : limit - 1;
                mq[j].st = nst;
                limit = nst;
            end
            if (inp) begin
                mq.push_back('{d: dd, st: 0});
                sent.push_back(dd);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; d_i = '0;
        #2;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        total++; if (count_o !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
        total++; if (q_o !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", q_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        @(negedge clk);
        reset_i = 1'b0;
        mq.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        int idx;
        sent.delete(); got.delete();
        ready_i = 1'b1;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            valid_i = (idx < 10);
            d_i     = 8'(idx + 1);
            @(negedge clk);
            total++; if (valid_o !== m_valid()) begin bad++; $display("FAIL stream_valid cyc=%0d got=%b want=%b", i, valid_o, m_valid()); end
            total++; if (count_o !== CW'(m_count())) begin bad++; $display("FAIL stream_count cyc=%0d got=%0d want=%0d", i, count_o, m_count()); end
            total++; if (ready_o !== m_ready(ready_i)) begin bad++; $display("FAIL stream_ready cyc=%0d got=%b want=%b", i, ready_o, m_ready(ready_i)); end
            if (m_valid()) begin
                total++; if (q_o !== m_q()) begin bad++; $display("FAIL stream_q cyc=%0d got=%h want=%h", i, q_o, m_q()); end
            end
            if (i == 3) begin
                total++; if (valid_o !== 1'b1 || q_o !== 8'h01) begin bad++; $display("FAIL stream_first got=%b/%h want=1/01", valid_o, q_o); end
            end
            if (i >= 3 && i <= 9) begin
                total++; if (count_o !== CW'(3)) begin bad++; $display("FAIL stream_steady cyc=%0d got=%0d want=3", i, count_o); end
            end
            if (valid_i && ready_o) idx++;
            tick();
        end
        valid_i = 1'b0;
        total++; if (got.size() != 10) begin bad++; $display("FAIL stream_len got=%0d want=10", got.size()); end
        foreach (got[k]) begin
            total++; if (got[k] !== 8'(k + 1)) begin bad++; $display("FAIL stream_order idx=%0d got=%h want=%h", k, got[k], 8'(k + 1)); end
        end
    endtask

    task automatic test_fill_stall();
        logic [NB-1:0] words [4];
        int idx;
        words = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        sent.delete(); got.delete();
        ready_i = 1'b0;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            valid_i = (idx < 4);
            d_i     = words[idx < 4 ? idx : 3];
            @(negedge clk);
            total++; if (ready_o !== m_ready(ready_i)) begin bad++; $display("FAIL fill_ready cyc=%0d got=%b want=%b", i, ready_o, m_ready(ready_i)); end
            total++; if (count_o !== CW'(m_count())) begin bad++; $display("FAIL fill_count cyc=%0d got=%0d want=%0d", i, count_o, m_count()); end
            if (valid_i && ready_o) idx++;
            tick();
        end
        @(negedge clk);
        total++; if (count_o !== CW'(3) || ready_o !== 1'b0) begin bad++; $display("FAIL fill_full got=%0d/%b want=3/0", count_o, ready_o); end
        total++; if (valid_o !== 1'b1 || q_o !== 8'hA1) begin bad++; $display("FAIL fill_head got=%b/%h want=1/a1", valid_o, q_o); end
        total++; if (sent.size() != 3) begin bad++; $display("FAIL fill_accepted got=%0d want=3", sent.size()); end
        ready_i = 1'b1;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL fill_release_ready got=%b want=1", ready_o); end
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        total++; if (count_o !== CW'(3)) begin bad++; $display("FAIL fill_swap_count got=%0d want=3", count_o); end
        total++; if (got.size() != 1 || sent.size() != 4) begin bad++; $display("FAIL fill_swap got=%0d/%0d want=1/4", got.size(), sent.size()); end
        repeat (D + 1) tick();
        foreach (words[k]) begin
            total++; if (k >= got.size() || got[k] !== words[k]) begin bad++; $display("FAIL fill_order idx=%0d want=%h", k, words[k]); end
        end
    endtask

    task automatic test_bubble();
        sent.delete(); got.delete();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_i = (i == 0) || (i == 2);
            d_i     = (i == 0) ? 8'h11 : 8'h22;
            tick();
        end
        valid_i = 1'b0;
        @(negedge clk);
        total++; if (count_o !== CW'(2)) begin bad++; $display("FAIL bubble_count got=%0d want=2", count_o); end
        total++; if (valid_o !== 1'b1 || q_o !== 8'h11) begin bad++; $display("FAIL bubble_head got=%b/%h want=1/11", valid_o, q_o); end
        total++; if (dut.v !== 3'b110) begin bad++; $display("FAIL bubble_stages got=%b want=110", dut.v); end
        ready_i = 1'b1;
        tick();
        @(negedge clk);
        total++; if (valid_o !== 1'b1 || q_o !== 8'h22) begin bad++; $display("FAIL bubble_next got=%b/%h want=1/22", valid_o, q_o); end
        repeat (D) tick();
    endtask

    task automatic test_flush();
        logic [NB-1:0] fill [3];
        fill = '{8'hB1, 8'hB2, 8'hB3};
        sent.delete(); got.delete();
        ready_i = 1'b0;
        foreach (fill[k]) begin
            valid_i = 1'b1;
            d_i     = fill[k];
            tick();
        end
        valid_i = 1'b1; d_i = 8'h55; ready_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", ready_o); end
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        total++; if (count_o !== '0 || valid_o !== 1'b0) begin bad++; $display("FAIL flush_clear got=%0d/%b want=0/0", count_o, valid_o); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_leak cyc=%0d got=%b/%h want=0", i, valid_o, q_o); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        sent.delete(); got.delete();
        ready_i = 1'b0;
        valid_i = 1'b1; d_i = 8'hC1; tick();
        valid_i = 1'b1; d_i = 8'hC2; tick();
        valid_i = 1'b1; d_i = 8'hC3;
        #3;
        reset_i = 1'b1;
        #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b want=0", valid_o); end
        total++; if (count_o !== '0) begin bad++; $display("FAIL areset_count got=%0d want=0", count_o); end
        total++; if (q_o !== 8'h00) begin bad++; $display("FAIL areset_q got=%h want=00", q_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL areset_ready got=%b want=1", ready_o); end
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0; valid_i = 1'b0;
        mq.delete();
        @(posedge clk);
        #1;
        total++; if (count_o !== '0) begin bad++; $display("FAIL areset_after got=%0d want=0", count_o); end
    endtask

    task automatic test_random();
        bit acc;
        sent.delete(); got.delete();
        valid_i = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!valid_i || acc) begin
                valid_i = ($urandom_range(0, 3) != 0);
                d_i     = 8'($urandom);
            end
            ready_i = (i % 2000 < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            @(negedge clk);
            acc = valid_i && ready_o;
            total++; if (valid_o !== m_valid()) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", i, valid_o, m_valid()); end
            total++; if (ready_o !== m_ready(ready_i)) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", i, ready_o, m_ready(ready_i)); end
            total++; if (count_o !== CW'(sent.size() - got.size())) begin bad++; $display("FAIL rand_count cyc=%0d got=%0d want=%0d", i, count_o, sent.size() - got.size()); end
            tick();
        end
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (D + 1) tick();
        total++; if (got.size() != sent.size()) begin bad++; $display("FAIL rand_len got=%0d want=%0d", got.size(), sent.size()); end
        foreach (got[k]) begin
            if (k < sent.size()) begin
                total++; if (got[k] !== sent[k]) begin bad++; $display("FAIL rand_order idx=%0d got=%h want=%h", k, got[k], sent[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill_stall();
        test_bubble();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
